// File: rtl/fast_square_pkg.sv
// Shared types and width helpers for the fast_square_array datapath.
// Imported by fast_square_lane and fast_square_array.
package fast_square_pkg;

  localparam int WIN_LOG2_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DRAIN
  } state_t;

  function automatic int sq_width(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int lanesum_width(input int w, input int l);
    return sq_width(w) + $clog2(l);
  endfunction

endpackage

// File: rtl/fast_square_lane.sv
// Combinational exact squarer for one signed lane.
// Uses leading-one detection plus a shift-add over the remaining magnitude bits.
module fast_square_lane
  import fast_square_pkg::*;
#(
  parameter  int WIDTH = 9,
  localparam int SQ_W  = sq_width(WIDTH)
) (
  input  logic signed [WIDTH-1:0] a,
  output logic        [SQ_W-1:0]  sqr
);

  localparam int MSB_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mag;
  logic [MSB_W-1:0] msb;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    msb = '0;
    sqr = '0;
    // The most-negative code negates to itself, which reads as 2^(WIDTH-1) unsigned.
    mag = a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
    for (int i = 0; i < WIDTH; i++) begin
      if (mag[i]) msb = MSB_W'(i);
    end
    // mag^2 = sum over set bits i of (mag << i); the leading one is always set.
    if (mag != '0) sqr = SQ_W'(mag) << msb;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < int'(msb) && mag[i]) sqr = sqr + (SQ_W'(mag) << i);
    end
  end

endmodule

// File: rtl/fast_square_array.sv
// Multi-lane exact squarer with a 2-cycle pipeline and a windowed sum-of-squares accumulator.
// Define FAST_SQUARE_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module fast_square_array
  import fast_square_pkg::*;
#(
  parameter  int WIDTH        = 9,
  parameter  int LANES        = 16,
  parameter  int ACC_W        = 32,
  parameter  int WIN_MAX_LOG2 = 16,
  localparam int SQ_W         = sq_width(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_valid,
  input  logic [LANES*WIDTH-1:0]  i_a,
  input  logic                    i_acc_start,
  input  logic [WIN_LOG2_W-1:0]   i_win_log2,
  output logic                    o_valid,
  output logic [LANES*SQ_W-1:0]   o_sqr,
  output logic                    o_busy,
  output logic                    o_acc_valid,
  output logic [ACC_W-1:0]        o_acc
);

  localparam int SUM_W = lanesum_width(WIDTH, LANES);
  localparam int CNT_W = WIN_MAX_LOG2 + 1;

  state_t                  state, state_nxt;
  logic [WIN_LOG2_W-1:0]   win_q, win_eff;
  logic [CNT_W-1:0]        cnt_q, cnt_eff, cnt_last;
  logic                    start_ok, tag_in, first_in, last_in;

  // Input-side window control: a start cycle counts as the first cycle of the window.
  always_comb begin
    start_ok = i_acc_start && (state == IDLE);
    win_eff  = win_q;
    if (start_ok) begin
      win_eff = (int'(i_win_log2) > WIN_MAX_LOG2) ? WIN_LOG2_W'(WIN_MAX_LOG2) : i_win_log2;
    end
    cnt_eff  = start_ok ? '0 : cnt_q;
    cnt_last = (CNT_W'(1) << win_eff) - CNT_W'(1);
    tag_in   = i_valid && (start_ok || state == COUNT);
    first_in = tag_in && (cnt_eff == '0);
    last_in  = tag_in && (cnt_eff == cnt_last);

    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = last_in ? DRAIN : COUNT;
      COUNT:   if (last_in) state_nxt = DRAIN;
      DRAIN:   if (o_acc_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      state <= IDLE;
      win_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        win_q <= win_eff;
        cnt_q <= CNT_W'(tag_in);
      end else if (tag_in) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage 1: input capture with window tags.
  logic [LANES*WIDTH-1:0] a1;
  logic                   v1, tag1, first1, last1;

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: data registers are reset as well, since every output must read 0 during reset.
    if (!rstn) begin
      a1     <= '0;
      v1     <= 1'b0;
      tag1   <= 1'b0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else begin
      v1     <= i_valid;
      tag1   <= tag_in;
      first1 <= first_in;
      last1  <= last_in;
      if (i_valid) a1 <= i_a;
    end
  end

  logic [LANES*SQ_W-1:0] sqr_c;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fast_square_lane #(.WIDTH(WIDTH)) u_lane (
      .a   (a1[k*WIDTH +: WIDTH]),
      .sqr (sqr_c[k*SQ_W +: SQ_W])
    );
  end

  // Stage 2: registered squares; o_sqr holds between valid beats.
  logic tag2, first2, last2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_sqr   <= '0;
      tag2    <= 1'b0;
      first2  <= 1'b0;
      last2   <= 1'b0;
    end else begin
      o_valid <= v1;
      tag2    <= tag1;
      first2  <= first1;
      last2   <= last1;
      if (v1) o_sqr <= sqr_c;
    end
  end

  // Stage 3: lane sum of one beat.
  logic [SUM_W-1:0] lane_sum, sum3;
  logic             tag3, first3, last3;

  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_W'(o_sqr[k*SQ_W +: SQ_W]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum3   <= '0;
      tag3   <= 1'b0;
      first3 <= 1'b0;
      last3  <= 1'b0;
    end else begin
      tag3   <= tag2;
      first3 <= first2;
      last3  <= last2;
      if (o_valid) sum3 <= lane_sum;
    end
  end

  // Stage 4: accumulator; the first tagged beat restarts it, the last publishes it.
  logic [ACC_W-1:0] acc_q, acc_base, acc_nxt;

`ifdef FAST_SQUARE_ACC_SAT_EN
  localparam int ACC_XW = ACC_W + 1;
  logic [ACC_XW-1:0] acc_wide;

  always_comb begin
    acc_base = first3 ? '0 : acc_q;
    acc_wide = {1'b0, acc_base} + ACC_XW'(sum3);
    // Once saturated, any further add overflows again, so the ceiling sticks.
    acc_nxt  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_base = first3 ? '0 : acc_q;
    acc_nxt  = acc_base + ACC_W'(sum3);
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      o_acc       <= '0;
      o_acc_valid <= 1'b0;
    end else begin
      o_acc_valid <= tag3 && last3;
      if (tag3) acc_q <= acc_nxt;
      if (tag3 && last3) o_acc <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_fast_square_array.sv
// Self-checking bench for fast_square_array: directed table, lane sweep, window and reset sequences.
// Square outputs are checked through a scoreboard keyed on the cycle each result is due.
module tb_fast_square_array;

  localparam int WIDTH        = 9;
  localparam int LANES        = 16;
  localparam int ACC_W        = 24;
  localparam int WIN_MAX_LOG2 = 16;
  localparam int SQ_W         = 2 * WIDTH - 1;
  localparam int AW           = LANES * WIDTH;
  localparam int OW           = LANES * SQ_W;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             i_valid = 1'b0;
  logic [AW-1:0]    i_a = '0;
  logic             i_acc_start = 1'b0;
  logic [4:0]       i_win_log2 = '0;
  logic             o_valid;
  logic [OW-1:0]    o_sqr;
  logic             o_busy;
  logic             o_acc_valid;
  logic [ACC_W-1:0] o_acc;

  fast_square_array #(
    .WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W), .WIN_MAX_LOG2(WIN_MAX_LOG2)
  ) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_a(i_a),
    .i_acc_start(i_acc_start), .i_win_log2(i_win_log2),
    .o_valid(o_valid), .o_sqr(o_sqr), .o_busy(o_busy),
    .o_acc_valid(o_acc_valid), .o_acc(o_acc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_acc_valid) acc_pulses <= acc_pulses + 1;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [OW-1:0] sqr;
    int            due;
  } sb_t;
  sb_t sb[$];

  // Square scoreboard: each pushed beat must appear exactly on its due cycle.
  always @(negedge clk) begin
    sb_t e;
    if (rstn) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("o_valid_latency", OW'(o_valid), OW'(1));
        check("o_sqr", o_sqr, e.sqr);
      end else if (o_valid) begin
        check("o_valid_spurious", OW'(o_valid), OW'(0));
      end
    end
  end

  function automatic logic [OW-1:0] model(input logic [AW-1:0] a);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      int s;
      s = $signed(a[k*WIDTH +: WIDTH]);
      r[k*SQ_W +: SQ_W] = SQ_W'(s * s);
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] fill(input int v);
    logic [AW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'(v);
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_a();
    logic [AW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  task automatic beat(input logic [AW-1:0] a, input logic [OW-1:0] exp,
                      input logic start = 1'b0, input logic [4:0] n = 5'd0);
    @(posedge clk); #1;
    i_valid = 1'b1; i_a = a; i_acc_start = start; i_win_log2 = n;
    sb.push_back('{sqr: exp, due: cyc + 2});
  endtask

  task automatic idle(input logic start = 1'b0, input logic [4:0] n = 5'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = rand_a(); i_acc_start = start; i_win_log2 = n;
  endtask

  task automatic at_cycle(input int target);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc < target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("cycle_reached", OW'(cyc), OW'(target));
  endtask

  typedef struct {
    logic signed [WIDTH-1:0] a0, a1, a2;
    int                      e0, e1, e2;
  } vec_t;
  vec_t vecs[4];

  function automatic logic [AW-1:0] vec_a(input vec_t v);
    logic [AW-1:0] r;
    r = '0;
    r[0*WIDTH +: WIDTH] = v.a0;
    r[1*WIDTH +: WIDTH] = v.a1;
    r[2*WIDTH +: WIDTH] = v.a2;
    return r;
  endfunction

  function automatic logic [OW-1:0] vec_exp(input vec_t v);
    logic [OW-1:0] r;
    r = '0;
    r[0*SQ_W +: SQ_W] = SQ_W'(v.e0);
    r[1*SQ_W +: SQ_W] = SQ_W'(v.e1);
    r[2*SQ_W +: SQ_W] = SQ_W'(v.e2);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n, p0;
    logic [AW-1:0] a;
    logic [ACC_W-1:0] ovf_exp;

    vecs[0] = '{a0: -256, a1: 255,  a2: -1,   e0: 65536, e1: 65025, e2: 1};
    vecs[1] = '{a0: 0,    a1: 1,    a2: -2,   e0: 0,     e1: 1,     e2: 4};
    vecs[2] = '{a0: 100,  a1: -100, a2: -128, e0: 10000, e1: 10000, e2: 16384};
    vecs[3] = '{a0: 127,  a1: -255, a2: 2,    e0: 16129, e1: 65025, e2: 4};

    // Reset with random stimulus: every output must stay 0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      i_valid = 1'($urandom); i_a = rand_a(); i_acc_start = 1'($urandom);
      i_win_log2 = 5'($urandom);
      @(negedge clk);
      check("rst_o_valid", OW'(o_valid), OW'(0));
      check("rst_o_sqr", o_sqr, OW'(0));
      check("rst_o_busy", OW'(o_busy), OW'(0));
      check("rst_o_acc_valid", OW'(o_acc_valid), OW'(0));
      check("rst_o_acc", OW'(o_acc), OW'(0));
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_acc_start = 1'b0;
    rstn = 1'b1;
    idle();
    idle();

    // Directed table, back to back, then o_sqr must hold once o_valid drops.
    for (int i = 0; i < 4; i++) beat(vec_a(vecs[i]), vec_exp(vecs[i]));
    for (int i = 0; i < 4; i++) idle();
    @(negedge clk);
    check("hold_o_valid", OW'(o_valid), OW'(0));
    check("hold_o_sqr", o_sqr, vec_exp(vecs[3]));

    // Sweep lane 0 over every code with random lanes elsewhere, no bubbles.
    for (int v = -256; v <= 255; v++) begin
      a = rand_a();
      a[0 +: WIDTH] = WIDTH'(v);
      beat(a, model(a));
    end
    for (int i = 0; i < 4; i++) idle();

    // Window N=2, four gapped beats of 3s, with an ignored start mid-window.
    p0 = acc_pulses;
    idle(1'b1, 5'd2);
    idle();
    check("win_busy", OW'(o_busy), OW'(1));
    n = 0;
    for (int b = 0; b < 4; b++) begin
      beat(fill(3), model(fill(3)));
      n = cyc;
      if (b == 1) idle(1'b1, 5'd0);
      else idle();
    end
    at_cycle(n + 4);
    check("win_acc_valid", OW'(o_acc_valid), OW'(1));
    check("win_acc", OW'(o_acc), OW'(576));
    check("win_busy_pulse", OW'(o_busy), OW'(1));
    i_acc_start = 1'b1; i_win_log2 = 5'd0;
    @(negedge clk);
    i_acc_start = 1'b0;
    check("win_acc_valid_after", OW'(o_acc_valid), OW'(0));
    check("win_busy_after", OW'(o_busy), OW'(0));
    check("win_acc_hold", OW'(o_acc), OW'(576));
    for (int i = 0; i < 6; i++) idle();
    check("win_single_pulse", OW'(acc_pulses - p0), OW'(1));

    // Overflow: N=8, start with the first beat, every lane most-negative.
`ifdef FAST_SQUARE_ACC_SAT_EN
    ovf_exp = 24'hFF_FFFF;
`else
    ovf_exp = 24'h00_0000;
`endif
    beat(fill(-256), model(fill(-256)), 1'b1, 5'd8);
    for (int b = 1; b < 256; b++) beat(fill(-256), model(fill(-256)));
    n = cyc;
    idle();
    at_cycle(n + 4);
    check("ovf_acc_valid", OW'(o_acc_valid), OW'(1));
    check("ovf_acc", OW'(o_acc), OW'(ovf_exp));
    for (int i = 0; i < 3; i++) idle();

    // Reset mid-window discards it; a fresh N=0 window then sums one beat.
    idle(1'b1, 5'd3);
    beat(fill(1), model(fill(1)));
    beat(fill(1), model(fill(1)));
    @(posedge clk); #1;
    i_valid = 1'b0; i_acc_start = 1'b0;
    rstn = 1'b0;
    sb.delete();
    p0 = acc_pulses;
    @(negedge clk);
    check("mid_rst_busy", OW'(o_busy), OW'(0));
    check("mid_rst_acc_valid", OW'(o_acc_valid), OW'(0));
    check("mid_rst_o_valid", OW'(o_valid), OW'(0));
    idle();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) idle();
    check("mid_rst_no_pulse", OW'(acc_pulses - p0), OW'(0));
    beat(fill(1), model(fill(1)), 1'b1, 5'd0);
    n = cyc;
    idle();
    at_cycle(n + 4);
    check("n0_acc_valid", OW'(o_acc_valid), OW'(1));
    check("n0_acc", OW'(o_acc), OW'(16));
    @(negedge clk);
    check("n0_acc_valid_after", OW'(o_acc_valid), OW'(0));
    check("n0_busy_after", OW'(o_busy), OW'(0));
    for (int i = 0; i < 4; i++) idle();
    check("sb_drained", OW'(sb.size()), OW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
